// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int RD_W  = $clog2(NREGS);

   typedef enum logic [1:0] {U_LSU, U_IXU1, U_IXU2, U_BRANCH} unit_e;

   typedef struct packed {
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] data;
   } wb_result_t;
endpackage

// File: rtl/wb_fifo.sv
// Per-unit result FIFO; ready depends only on occupancy, flush empties it synchronously.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  wb_result_t push_data,
   input  logic       pop,
   output wb_result_t head,
   output logic       empty,
   output logic       ready
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   wb_result_t      mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   assign ready   = (count < CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push & ready & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/writeback_arbiter.sv
// Buffers four unit results, arbitrates same-rd writes (lsu > ixu1 > ixu2 > branch) onto
// four registered write ports. Define WB_SCOREBOARD_EN to build the issue-side busy scoreboard.
module writeback_arbiter #(
   parameter int DEPTH = 2,
   parameter int XLEN  = wb_pkg::XLEN,
   parameter int NREGS = wb_pkg::NREGS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         lsu_res_valid,
   output logic                         lsu_res_ready,
   input  logic [$clog2(NREGS)-1:0]     lsu_res_rd,
   input  logic [XLEN-1:0]              lsu_res_data,
   input  logic                         ixu1_res_valid,
   output logic                         ixu1_res_ready,
   input  logic [$clog2(NREGS)-1:0]     ixu1_res_rd,
   input  logic [XLEN-1:0]              ixu1_res_data,
   input  logic                         ixu2_res_valid,
   output logic                         ixu2_res_ready,
   input  logic [$clog2(NREGS)-1:0]     ixu2_res_rd,
   input  logic [XLEN-1:0]              ixu2_res_data,
   input  logic                         branch_res_valid,
   output logic                         branch_res_ready,
   input  logic [$clog2(NREGS)-1:0]     branch_res_rd,
   input  logic [XLEN-1:0]              branch_res_data,
   output logic                         lsu_wr_en,
   output logic [$clog2(NREGS)-1:0]     lsu_rd,
   output logic [XLEN-1:0]              lsu_wr_data,
   output logic                         ixu1_wr_en,
   output logic [$clog2(NREGS)-1:0]     ixu1_rd,
   output logic [XLEN-1:0]              ixu1_wr_data,
   output logic                         ixu2_wr_en,
   output logic [$clog2(NREGS)-1:0]     ixu2_rd,
   output logic [XLEN-1:0]              ixu2_wr_data,
   output logic                         branch_wr_en,
   output logic [$clog2(NREGS)-1:0]     branch_rd,
   output logic [XLEN-1:0]              branch_wr_data,
   input  logic [3:0]                   iss_valid,
   input  logic [4*$clog2(NREGS)-1:0]   iss_rd,
   output logic [NREGS-1:0]             busy
);
   import wb_pkg::wb_result_t;
   import wb_pkg::U_LSU;
   import wb_pkg::U_IXU1;
   import wb_pkg::U_IXU2;
   import wb_pkg::U_BRANCH;

   localparam int RD_W = $clog2(NREGS);
   localparam int NU   = 4;

   logic [NU-1:0]   res_valid;
   logic [NU-1:0]   res_ready;
   logic [NU-1:0]   fifo_empty;
   logic [NU-1:0]   pop;
   logic [NU-1:0]   grant;
   logic            blocked;
   wb_result_t      res_in [NU];
   wb_result_t      head   [NU];

   logic [NU-1:0]   wr_en_q;
   logic [RD_W-1:0] rd_q   [NU];
   logic [XLEN-1:0] data_q [NU];

   assign res_valid        = {branch_res_valid, ixu2_res_valid, ixu1_res_valid, lsu_res_valid};
   assign res_in[U_LSU]    = {lsu_res_rd, lsu_res_data};
   assign res_in[U_IXU1]   = {ixu1_res_rd, ixu1_res_data};
   assign res_in[U_IXU2]   = {ixu2_res_rd, ixu2_res_data};
   assign res_in[U_BRANCH] = {branch_res_rd, branch_res_data};

   for (genvar u = 0; u < NU; u++) begin : g_fifo
      wb_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .push      (res_valid[u]),
         .push_data (res_in[u]),
         .pop       (pop[u]),
         .head      (head[u]),
         .empty     (fifo_empty[u]),
         .ready     (res_ready[u])
      );
   end

   // A head is granted unless a higher-priority non-empty head targets the same rd.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant   = '0;
      pop     = '0;
      blocked = 1'b0;
      for (int u = 0; u < NU; u++) begin
         if (!fifo_empty[u]) begin
            if (head[u].rd == '0) begin
               pop[u] = 1'b1;
            end else begin
               blocked = 1'b0;
               for (int h = 0; h < u; h++) begin
                  if (!fifo_empty[h] && head[h].rd == head[u].rd) blocked = 1'b1;
               end
               grant[u] = ~blocked;
               pop[u]   = ~blocked;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q <= '0;
         for (int u = 0; u < NU; u++) begin
            rd_q[u]   <= '0;
            data_q[u] <= '0;
         end
      end else if (flush) begin
         wr_en_q <= '0;
      end else begin
         wr_en_q <= grant;
         for (int u = 0; u < NU; u++) begin
            if (grant[u]) begin
               rd_q[u]   <= head[u].rd;
               data_q[u] <= head[u].data;
            end
         end
      end
   end

   assign lsu_res_ready    = res_ready[U_LSU];
   assign ixu1_res_ready   = res_ready[U_IXU1];
   assign ixu2_res_ready   = res_ready[U_IXU2];
   assign branch_res_ready = res_ready[U_BRANCH];

   assign lsu_wr_en      = wr_en_q[U_LSU];
   assign lsu_rd         = rd_q[U_LSU];
   assign lsu_wr_data    = data_q[U_LSU];
   assign ixu1_wr_en     = wr_en_q[U_IXU1];
   assign ixu1_rd        = rd_q[U_IXU1];
   assign ixu1_wr_data   = data_q[U_IXU1];
   assign ixu2_wr_en     = wr_en_q[U_IXU2];
   assign ixu2_rd        = rd_q[U_IXU2];
   assign ixu2_wr_data   = data_q[U_IXU2];
   assign branch_wr_en   = wr_en_q[U_BRANCH];
   assign branch_rd      = rd_q[U_BRANCH];
   assign branch_wr_data = data_q[U_BRANCH];

`ifdef WB_SCOREBOARD_EN
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_next;

   // Clears from presented writes are applied before issue sets so a same-cycle set wins.
   always_comb begin
      busy_next = busy_q;
      for (int u = 0; u < NU; u++) begin
         if (wr_en_q[u]) busy_next[rd_q[u]] = 1'b0;
      end
      for (int i = 0; i < NU; i++) begin
         if (iss_valid[i] && iss_rd[i*RD_W +: RD_W] != '0) busy_next[iss_rd[i*RD_W +: RD_W]] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        busy_q <= '0;
      else if (flush) busy_q <= '0;
      else            busy_q <= busy_next;
   end

   assign busy = busy_q;
`else
   logic unused_iss;
   assign unused_iss = ^{iss_valid, iss_rd};
   assign busy       = '0;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued per unit at acceptance
// and popped by a monitor whenever a write port is enabled.
module tb_writeback_arbiter;
   import wb_pkg::*;

`ifdef WB_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [3:0]  v;
   logic [4:0]  rdi [4];
   logic [31:0] di  [4];
   logic [3:0]  rdy;
   logic [3:0]  we;
   logic [4:0]  wr_rd   [4];
   logic [31:0] wr_data [4];
   logic [3:0]  iss_valid;
   logic [19:0] iss_rd;
   logic [31:0] busy;

   int total = 0;
   int bad   = 0;

   wb_result_t  exp_q [4][$];
   logic [31:0] regfile [32];

   always #5 clk = ~clk;

   writeback_arbiter #(.DEPTH(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .lsu_res_valid    (v[0]),
      .lsu_res_ready    (rdy[0]),
      .lsu_res_rd       (rdi[0]),
      .lsu_res_data     (di[0]),
      .ixu1_res_valid   (v[1]),
      .ixu1_res_ready   (rdy[1]),
      .ixu1_res_rd      (rdi[1]),
      .ixu1_res_data    (di[1]),
      .ixu2_res_valid   (v[2]),
      .ixu2_res_ready   (rdy[2]),
      .ixu2_res_rd      (rdi[2]),
      .ixu2_res_data    (di[2]),
      .branch_res_valid (v[3]),
      .branch_res_ready (rdy[3]),
      .branch_res_rd    (rdi[3]),
      .branch_res_data  (di[3]),
      .lsu_wr_en        (we[0]),
      .lsu_rd           (wr_rd[0]),
      .lsu_wr_data      (wr_data[0]),
      .ixu1_wr_en       (we[1]),
      .ixu1_rd          (wr_rd[1]),
      .ixu1_wr_data     (wr_data[1]),
      .ixu2_wr_en       (we[2]),
      .ixu2_rd          (wr_rd[2]),
      .ixu2_wr_data     (wr_data[2]),
      .branch_wr_en     (we[3]),
      .branch_rd        (wr_rd[3]),
      .branch_wr_data   (wr_data[3]),
      .iss_valid        (iss_valid),
      .iss_rd           (iss_rd),
      .busy             (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      v         = '0;
      iss_valid = '0;
   endtask

   // Queue the expected write only if the FIFO will accept this result at the coming edge.
   task automatic drive(input int u, input logic [4:0] rd, input logic [31:0] d);
      v[u]   = 1'b1;
      rdi[u] = rd;
      di[u]  = d;
      if (rdy[u] && rd != 5'd0 && !flush) exp_q[u].push_back({rd, d});
   endtask

   task automatic issue(input int slot, input logic [4:0] rd);
      iss_valid[slot]      = 1'b1;
      iss_rd[slot*5 +: 5]  = rd;
   endtask

   task automatic clear_model();
      for (int u = 0; u < 4; u++) exp_q[u].delete();
   endtask

   // Write monitor: compares every enabled port against its unit's queue, then models the register file.
   always @(negedge clk) begin
      wb_result_t e;
      if (!rst) begin
         for (int u = 0; u < 4; u++) begin
            if (we[u]) begin
               if (exp_q[u].size() == 0) begin
                  check($sformatf("unexpected_wr_u%0d", u), we[u], 1'b0);
               end else begin
                  e = exp_q[u].pop_front();
                  check($sformatf("wr_rd_u%0d", u), wr_rd[u], e.rd);
                  check($sformatf("wr_data_u%0d", u), wr_data[u], e.data);
               end
            end
         end
         for (int u = 0; u < 4; u++) if (we[u]) regfile[wr_rd[u]] = wr_data[u];
      end
   end

   initial begin
      int   n1;
      int   n2;
      logic a1;
      logic a2;

      for (int r = 0; r < 32; r++) regfile[r] = '0;
      rst = 1'b1; flush = 1'b0; v = '0; iss_valid = '0; iss_rd = '0;
      for (int u = 0; u < 4; u++) begin rdi[u] = '0; di[u] = '0; end

      // Reset state
      step();
      for (int u = 0; u < 4; u++) begin
         check($sformatf("rst_we_u%0d", u), we[u], 1'b0);
         check($sformatf("rst_rd_u%0d", u), wr_rd[u], 5'd0);
         check($sformatf("rst_data_u%0d", u), wr_data[u], 32'd0);
         check($sformatf("rst_ready_u%0d", u), rdy[u], 1'b1);
      end
      check("rst_busy", busy, 32'd0);
      step();
      rst = 1'b0;
      step();

      // Single write: one-cycle latency to wr_en, enabled for exactly one cycle
      drive(0, 5'd5, 32'hDEADBEEF);
      step(); idle();
      check("single_we_early", we[0], 1'b0);
      step();
      check("single_we", we[0], 1'b1);
      check("single_rd", wr_rd[0], 5'd5);
      check("single_data", wr_data[0], 32'hDEADBEEF);
      step();
      check("single_we_off", we[0], 1'b0);

      // Same-rd conflict: lsu first, branch one cycle later and wins the final value
      drive(0, 5'd7, 32'h1);
      drive(3, 5'd7, 32'h2);
      step(); idle();
      step();
      check("conf_lsu_we", we[0], 1'b1);
      check("conf_br_we_hold", we[3], 1'b0);
      check("conf_lsu_data", wr_data[0], 32'h1);
      step();
      check("conf_lsu_we_off", we[0], 1'b0);
      check("conf_br_we", we[3], 1'b1);
      check("conf_br_data", wr_data[3], 32'h2);
      step();
      check("conf_final_r7", regfile[7], 32'h2);

      // Back-pressure: ixu2 held behind three ixu1 rd=9 writes
      n1 = 0; n2 = 0;
      for (int c = 0; c < 10; c++) begin
         idle();
         if (c <= 5) check($sformatf("bp_ixu2_ready_c%0d", c), rdy[2], (c >= 2 && c <= 4) ? 1'b0 : 1'b1);
         a1 = 1'b0; a2 = 1'b0;
         if (n1 < 3) begin a1 = rdy[1]; drive(1, 5'd9, 32'h100 + n1); end
         if (n2 < 3) begin a2 = rdy[2]; drive(2, 5'd9, 32'h200 + n2); end
         step();
         if (a1) n1++;
         if (a2) n2++;
      end
      idle();
      repeat (3) step();
      check("bp_ixu1_sent", n1, 3);
      check("bp_ixu2_sent", n2, 3);
      check("bp_final_r9", regfile[9], 32'h202);

      // Scoreboard set, clear on writeback, and set-wins
      issue(1, 5'd3);
      step(); idle();
      check("sb_set", busy[3], SB);
      drive(1, 5'd3, 32'h33);
      step(); idle();
      check("sb_pending", busy[3], SB);
      step();
      check("sb_wr_present", we[1], 1'b1);
      check("sb_hold_during_wr", busy[3], SB);
      step();
      check("sb_cleared", busy[3], 1'b0);
      issue(1, 5'd3);
      step(); idle();
      drive(1, 5'd3, 32'h34);
      step(); idle();
      step();
      check("sb_wr2_present", we[1], 1'b1);
      issue(1, 5'd3);
      step(); idle();
      check("sb_set_wins", busy[3], SB);
      check("sb_bit0", busy[0], 1'b0);

      // rd = 0 is discarded without a write
      drive(1, 5'd0, 32'hBAD);
      step(); idle();
      step();
      check("rd0_no_we_a", we[1], 1'b0);
      step();
      check("rd0_no_we_b", we[1], 1'b0);

      // Flush: in-flight write completes, queued results and busy bits vanish
      drive(0, 5'd16, 32'h160);
      step(); idle();
      for (int u = 0; u < 4; u++) drive(u, 5'(12 + u), 32'h1200 + u);
      issue(0, 5'd20);
      issue(1, 5'd21);
      step(); idle();
      flush = 1'b1;
      check("fl_busy20", busy[20], SB);
      check("fl_busy21", busy[21], SB);
      check("fl_inflight_we", we[0], 1'b1);
      step();
      flush = 1'b0;
      clear_model();
      check("fl_busy_clear", busy, 32'd0);
      check("fl_we_off", we, 4'd0);
      check("fl_ready", rdy, 4'hF);
      repeat (3) step();
      check("fl_r16_written", regfile[16], 32'h160);
      check("fl_r12_untouched", regfile[12], 32'd0);

      // Reset mid-stream with two results buffered in ixu1
      drive(0, 5'd26, 32'hA);
      drive(1, 5'd26, 32'hB);
      step(); idle();
      drive(1, 5'd27, 32'hC);
      step(); idle();
      check("rs_ixu1_full", rdy[1], 1'b0);
      rst = 1'b1;
      clear_model();
      #1;
      check("rs_we", we, 4'd0);
      check("rs_busy", busy, 32'd0);
      check("rs_ready", rdy, 4'hF);
      check("rs_lsu_rd", wr_rd[0], 5'd0);
      step(); step();
      rst = 1'b0;
      repeat (4) step();
      check("rs_r26_untouched", regfile[26], 32'd0);
      check("rs_r27_untouched", regfile[27], 32'd0);

      for (int u = 0; u < 4; u++) check($sformatf("drain_u%0d", u), exp_q[u].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
